// File: rtl/fp_pkg.sv
// Shared definitions for the FP add normalize stage and the rounding stage
// that follows it.
//   EXP_MAX / EXP_W : largest biased exponent and exponent width
//   SUM_W / FRAC_W / GRS_W / LZ_W : datapath widths
//   pass_t : special-case flags, signs and rounding mode carried alongside the data
//   res_t  : one normalized result as held by S2 and the optional skid buffer
package fp_pkg;
  localparam int EXP_MAX = 255;
  localparam int EXP_W   = $clog2(EXP_MAX + 1);
  localparam int SUM_W   = 49;
  localparam int FRAC_W  = 23;
  localparam int GRS_W   = 24;
  localparam int LZ_W    = 6;

  typedef struct packed {
    logic       nan;
    logic       inf1;
    logic       inf2;
    logic       sign1;
    logic       sign2;
    logic       sign_res;
    logic [2:0] rm;
  } pass_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp_n;
    logic [FRAC_W-1:0] mant;
    logic [GRS_W-1:0]  grs;
    logic              uf;
    pass_t             pass;
  } res_t;
endpackage

// File: rtl/fp_add_normalize_if.sv
// Handshake + data bundle around the normalize stage.
//   upstream  : in_valid/in_ready, sum_mant, exp_in, special flags, signs, rm_in
//   downstream: out_valid/out_ready, exp_norm, mantissa_norm, grs, underflow,
//               registered pass-through copies (NaN, inf1, inf2, sign1, sign2, sign_res, rm)
// slave = the normalize block, master = the producer/consumer around it.
interface fp_add_normalize_if;
  import fp_pkg::*;
  logic              in_valid, in_ready;
  logic [SUM_W-1:0]  sum_mant;
  logic [EXP_W-1:0]  exp_in;
  logic              nan_in, inf1_in, inf2_in, sign1_in, sign2_in, sign_res_in;
  logic [2:0]        rm_in;
  logic              out_valid, out_ready;
  logic [EXP_W-1:0]  exp_norm;
  logic [FRAC_W-1:0] mantissa_norm;
  logic [GRS_W-1:0]  grs;
  logic              underflow;
  logic              NaN, inf1, inf2, sign1, sign2, sign_res;
  logic [2:0]        rm;

  modport slave (
    input  in_valid, sum_mant, exp_in, nan_in, inf1_in, inf2_in, sign1_in, sign2_in,
           sign_res_in, rm_in, out_ready,
    output in_ready, out_valid, exp_norm, mantissa_norm, grs, underflow,
           NaN, inf1, inf2, sign1, sign2, sign_res, rm
  );
  modport master (
    output in_valid, sum_mant, exp_in, nan_in, inf1_in, inf2_in, sign1_in, sign2_in,
           sign_res_in, rm_in, out_ready,
    input  in_ready, out_valid, exp_norm, mantissa_norm, grs, underflow,
           NaN, inf1, inf2, sign1, sign2, sign_res, rm
  );
endinterface

// File: rtl/lzc48.sv
// Combinational 48-bit leading-zero counter.
//   a    : input vector
//   cnt  : number of leading zeros (48 when a is all zero)
//   zero : a == 0
module lzc48
  import fp_pkg::*;
(
  input  logic [47:0]     a,
  output logic [LZ_W-1:0] cnt,
  output logic            zero
);
  // Scan upward; the highest set bit is the last to write cnt.
  always_comb begin
    cnt = LZ_W'(48);
    for (int i = 0; i < 48; i++)
      if (a[i]) cnt = LZ_W'(47 - i);
  end

  assign zero = ~|a;
endmodule

// File: rtl/fp_add_normalize.sv
// Two-stage normalize step of an FP adder.
//   clk, rst : clock, asynchronous active-high reset
//   io       : fp_add_normalize_if.slave (upstream/downstream handshakes + data)
// S1 registers the inputs and the leading-zero count; S2 registers the
// shifted result. Build option FP_NORM_SKID_EN adds a 2-entry skid buffer
// after S2 and drives in_ready from a register.
module fp_add_normalize
  import fp_pkg::*;
(
  input logic              clk,
  input logic              rst,
  fp_add_normalize_if.slave io
);
  pass_t            in_pass;
  logic [LZ_W-1:0]  lz;
  logic             lz_zero;
  logic             v1, v2, adv1, adv2, acc, in_rdy;
  logic [SUM_W-1:0] s1_sum;
  logic [EXP_W-1:0] s1_exp;
  logic [LZ_W-1:0]  s1_lz;
  logic             s1_zero;
  pass_t            s1_pass;
  res_t             nxt, s2, out_res;
  logic [FRAC_W+GRS_W-1:0] sh;

  assign in_pass = {io.nan_in, io.inf1_in, io.inf2_in, io.sign1_in, io.sign2_in,
                    io.sign_res_in, io.rm_in};

  lzc48 u_lzc (.a(io.sum_mant[SUM_W-2:0]), .cnt(lz), .zero(lz_zero));

  assign acc  = io.in_valid & in_rdy;
  assign adv1 = ~v1 | adv2;
  assign io.in_ready = in_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; s1_sum <= '0; s1_exp <= '0; s1_lz <= '0; s1_zero <= 1'b0; s1_pass <= '0;
      v2 <= 1'b0; s2 <= '0;
    end else begin
      if (adv1) begin
        v1 <= acc;
        if (acc) begin
          s1_sum  <= io.sum_mant;
          s1_exp  <= io.exp_in;
          s1_lz   <= lz;
          s1_zero <= lz_zero & ~io.sum_mant[SUM_W-1];
          s1_pass <= in_pass;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) s2 <= nxt;
      end
    end
  end

  // Normalization. Only bits below the hidden bit are shifted, so the
  // hidden bit drops out and the result is fraction:grs directly.
  always_comb begin
    nxt      = '0;
    nxt.pass = s1_pass;
    sh       = s1_sum[FRAC_W+GRS_W-1:0] << s1_lz;
    if (s1_sum[SUM_W-1]) begin
      // Carry out: shift right by one, folding both low bits into sticky.
      // exp_in tops out at 254, so 255 is reachable and left for rounding to flag.
      nxt.exp_n = s1_exp + EXP_W'(1);
      nxt.mant  = s1_sum[SUM_W-2:GRS_W+1];
      nxt.grs   = {s1_sum[GRS_W:2], s1_sum[1] | s1_sum[0]};
    end else if (!s1_zero) begin
      if (EXP_W'(s1_lz) >= s1_exp) nxt.uf = 1'b1;
      else begin
        nxt.exp_n = s1_exp - EXP_W'(s1_lz);
        nxt.mant  = sh[FRAC_W+GRS_W-1:GRS_W];
        nxt.grs   = sh[GRS_W-1:0];
      end
    end
  end

`ifdef FP_NORM_SKID_EN
  logic [1:0] cnt, cnt_pop, cnt_n;
  logic [2:0] occ_n;
  logic       pop_f, push, direct, rdy_q, v1_n, v2_n;
  res_t       q0, q1;

  // S2 goes straight out when nothing is queued ahead of it; otherwise it
  // joins the queue behind older results to keep order.
  assign pop_f   = io.out_ready & (cnt != 2'd0);
  assign cnt_pop = cnt - {1'b0, pop_f};
  assign direct  = v2 & (cnt == 2'd0) & io.out_ready;
  assign push    = v2 & ~direct & (cnt_pop != 2'd2);
  assign cnt_n   = cnt_pop + {1'b0, push};
  assign adv2    = ~v2 | direct | push;
  assign v1_n    = adv1 ? acc : v1;
  assign v2_n    = adv2 ? v1 : v2;
  assign occ_n   = {2'b0, v1_n} + {2'b0, v2_n} + {1'b0, cnt_n};
  assign in_rdy  = rdy_q;
  assign io.out_valid = v2 | (cnt != 2'd0);
  assign out_res = (cnt != 2'd0) ? q0 : s2;

  // Ready is a cycle stale, so it is only advertised while a full entry of
  // slack remains; the queue can then never be overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0; rdy_q <= 1'b0; q0 <= '0; q1 <= '0;
    end else begin
      cnt   <= cnt_n;
      rdy_q <= occ_n < 3'd3;
      if (pop_f) q0 <= q1;
      if (push) begin
        if (cnt_pop == 2'd0) q0 <= s2;
        else                 q1 <= s2;
      end
    end
  end
`else
  assign adv2    = ~v2 | io.out_ready;
  assign in_rdy  = adv1;
  assign io.out_valid = v2;
  assign out_res = s2;
`endif

  assign io.exp_norm      = out_res.exp_n;
  assign io.mantissa_norm = out_res.mant;
  assign io.grs           = out_res.grs;
  assign io.underflow     = out_res.uf;
  assign {io.NaN, io.inf1, io.inf2, io.sign1, io.sign2, io.sign_res, io.rm} = out_res.pass;
endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed bench for fp_add_normalize: single vectors with hand-computed
// results, streaming with and without backpressure, and reset mid-flight.
module tb_fp_add_normalize;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_normalize_if bus ();
  fp_add_normalize dut (.clk(clk), .rst(rst), .io(bus.slave));

  int total = 0;
  int bad   = 0;
  logic [8:0] pass_o;
  assign pass_o = {bus.NaN, bus.inf1, bus.inf2, bus.sign1, bus.sign2, bus.sign_res, bus.rm};

`ifdef FP_NORM_SKID_EN
  localparam int BP_ACC = 3;
`else
  localparam int BP_ACC = 2;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [48:0] s, input logic [7:0] e, input logic [8:0] p);
    bus.in_valid = v;
    bus.sum_mant = s;
    bus.exp_in   = e;
    {bus.nan_in, bus.inf1_in, bus.inf2_in, bus.sign1_in, bus.sign2_in, bus.sign_res_in, bus.rm_in} = p;
  endtask

  // One isolated transaction: accept, latency of 2, then full field check.
  task automatic one(input string tag, input logic [48:0] s, input logic [7:0] e, input logic [8:0] p,
                     input logic [7:0] xe, input logic [22:0] xm, input logic [23:0] xg, input logic xu);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(1'b1, s, e, p);
    #1 chk({tag, "_rdy"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1 drive(1'b0, '0, 8'd1, '0);
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1 chk({tag, "_vld"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_exp"},  64'(bus.exp_norm), 64'(xe));
    chk({tag, "_mant"}, 64'(bus.mantissa_norm), 64'(xm));
    chk({tag, "_grs"},  64'(bus.grs), 64'(xg));
    chk({tag, "_uf"},   64'(bus.underflow), 64'(xu));
    chk({tag, "_pass"}, 64'(pass_o), 64'(p));
    @(posedge clk);
    #1 chk({tag, "_done"}, 64'(bus.out_valid), 64'(0));
  endtask

  // n inputs of 2^24 (lz=23) with exp_in=base+i; out_ready held low for the
  // first 'stall' cycles. Checks order, hold-while-stalled and counts.
  task automatic stream(input string tag, input int n, input int stall, input logic [7:0] base,
                        output int acc_at_stall, output int cyc);
    int idx = 0, k = 0;
    logic ir, ov;
    logic [7:0] oe;
    logic [8:0] op;
    cyc = 0;
    acc_at_stall = 0;
    while ((idx < n || k < n) && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = (cyc >= stall);
      if (idx < n) drive(1'b1, 49'h0_0000_0100_0000, 8'(base + idx), 9'(idx));
      else         drive(1'b0, '0, 8'd1, '0);
      #1;
      ir = bus.in_ready; ov = bus.out_valid; oe = bus.exp_norm; op = pass_o;
      if (cyc == stall) acc_at_stall = idx;
      if (stall > 0 && cyc == stall - 1) chk({tag, "_rdy_low"}, 64'(ir), 64'(0));
      if (ov && !bus.out_ready) chk({tag, "_hold"}, 64'(oe), 64'(8'(base + k - 23)));
      @(posedge clk);
      if (bus.in_valid && ir) idx++;
      if (ov && bus.out_ready) begin
        chk({tag, "_ord_exp"}, 64'(oe), 64'(8'(base + k - 23)));
        chk({tag, "_ord_tag"}, 64'(op), 64'(9'(k)));
        k++;
      end
      cyc++;
    end
    chk({tag, "_in_cnt"},  64'(idx), 64'(n));
    chk({tag, "_out_cnt"}, 64'(k), 64'(n));
    @(negedge clk);
    drive(1'b0, '0, 8'd1, '0);
    #1 chk({tag, "_no_dup"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    int acc, cyc, seen;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, 8'd1, '0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  64'(bus.out_valid), 64'(0));
    chk("rst_exp",  64'(bus.exp_norm), 64'(0));
    chk("rst_mant", 64'(bus.mantissa_norm), 64'(0));
    chk("rst_grs",  64'(bus.grs), 64'(0));
    chk("rst_uf",   64'(bus.underflow), 64'(0));
    chk("rst_pass", 64'(pass_o), 64'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_rdy", 64'(bus.in_ready), 64'(1));

    // Directed single vectors
    one("carry",  49'h1_0000_0000_0000, 8'd127, 9'h000, 8'd128, 23'h0, 24'h0, 1'b0);
    one("cancel", 49'h0_0000_0100_0000, 8'd127, 9'h1A5, 8'd104, 23'h0, 24'h0, 1'b0);
    one("uflow",  49'h0_0000_0100_0000, 8'd10,  9'h000, 8'd0,   23'h0, 24'h0, 1'b1);
    one("zero",   49'h0,                8'd100, 9'h000, 8'd0,   23'h0, 24'h0, 1'b0);
    one("zeronan",49'h0,                8'd100, 9'h100, 8'd0,   23'h0, 24'h0, 1'b0);
    one("cy255",  49'h1_8000_0000_0003, 8'd254, 9'h007, 8'd255, 23'h400000, 24'h000001, 1'b0);
    one("lz0",    49'h0_C000_0080_0001, 8'd50,  9'h0C2, 8'd50,  23'h400000, 24'h800001, 1'b0);
    one("lz46",   49'h0_0000_0000_0003, 8'd100, 9'h000, 8'd54,  23'h400000, 24'h0, 1'b0);
    one("lz_eq",  49'h0_0000_0100_0000, 8'd23,  9'h000, 8'd0,   23'h0, 24'h0, 1'b1);
    one("lz_lt",  49'h0_0000_0100_0000, 8'd24,  9'h000, 8'd1,   23'h0, 24'h0, 1'b0);

    // Full throughput: one result per cycle, no bubbles
    stream("thru", 6, 0, 8'd100, acc, cyc);
    chk("thru_cyc", 64'(cyc), 64'(8));

    // Backpressure
    stream("bp", 4, 5, 8'd100, acc, cyc);
    chk("bp_acc", 64'(acc), 64'(BP_ACC));

    // Reset mid-flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, 49'h1_0000_0000_0000, 8'd127, 9'h1FF);
    @(posedge clk);
    @(posedge clk);
    #1 drive(1'b0, '0, 8'd1, '0);
    chk("mid_vld_pre", 64'(bus.out_valid), 64'(1));
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_vld",  64'(bus.out_valid), 64'(0));
    chk("mid_exp",  64'(bus.exp_norm), 64'(0));
    chk("mid_mant", 64'(bus.mantissa_norm), 64'(0));
    chk("mid_grs",  64'(bus.grs), 64'(0));
    chk("mid_uf",   64'(bus.underflow), 64'(0));
    chk("mid_pass", 64'(pass_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk("mid_rdy", 64'(bus.in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("mid_stale", 64'(seen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_normalize.md
FP_ADD_NORMALIZE -- requirements
Module: fp_add_normalize

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid / in_ready  input / output  1 / 1  upstream handshake; a transfer occurs when both are high on a clock edge.
REQ-004 sum_mant  input  49  raw adder magnitude: [48]=carry, [47]=hidden, [46:24]=fraction, [23:0]=guard/round/sticky field.
REQ-005 exp_in  input  8  pre-normalization exponent, range 1..254.
REQ-006 nan_in, inf1_in, inf2_in, sign1_in, sign2_in, sign_res_in  input  1 each  special-case flags and signs, passed through unchanged.
REQ-007 rm_in  input  3  rounding mode, passed through unchanged.
REQ-008 out_valid / out_ready  output / input  1 / 1  downstream handshake to the rounding stage.
REQ-009 exp_norm  output  8  normalized exponent.
REQ-010 mantissa_norm  output  23  normalized fraction, hidden bit removed.
REQ-011 grs  output  24  [23]=G, [22]=R, [21:0]=sticky-contributing bits.
REQ-012 underflow  output  1  exponent would reach 0 or below; the result flushes.
REQ-013 NaN, inf1, inf2, sign1, sign2, sign_res, rm  output  as input  registered copies of the pass-through fields.

Function
REQ-014 Two-stage pipeline.
- S1 registers the inputs plus the 6-bit leading-zero count of sum_mant[47:0].
- S2 registers the shifted result.
- Latency is exactly 2 cycles from an accepted input to out_valid, when there is no backpressure.
REQ-015 Carry case (sum_mant[48]=1):
- Shift right by 1; exp_norm = exp_in+1.
- New grs[0] = OR of the two lowest bits shifted out/retained; no sticky information is lost.
REQ-016 Normal case (sum_mant[48]=0, sum_mant≠0):
- lz = leading zeros of [47:0].
- Shift left by lz; exp_norm = exp_in−lz.
- Vacated low bits are zero.
REQ-017 If lz ≥ exp_in in the normal case: underflow=1, exp_norm=0, mantissa_norm=0, grs=0.
REQ-018 If sum_mant == 0: exp_norm=0, mantissa_norm=0, grs=0, underflow=0 (exact zero).
REQ-019 exp_in+1 = 255 in the carry case SHALL be emitted as 255, with no saturation; the rounding stage flags overflow.
REQ-020 Each stage holds its data while the following stage is stalled; a stage advances when it is empty or the next stage advances.
- in_ready = S1 empty or S1 advancing.
- A full pipeline with out_ready low SHALL hold in_ready low.
REQ-021 Simultaneous accept and emit on the same edge SHALL sustain one result per cycle; no bubble is inserted.
REQ-022 Output data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Results SHALL leave in acceptance order; none are dropped or duplicated.

Reset
REQ-024 On rst, all stage-valid flags clear and every output is 0: out_valid=0, exp_norm=0, mantissa_norm=0, grs=0, underflow=0, flags=0, rm=0.
- in_ready=1 from the first edge after rst deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight data; nothing in flight is emitted after release.

Configuration
REQ-026 Macro FP_NORM_SKID_EN.
- When defined: a 2-entry skid buffer follows S2; in_ready is driven from a register with no combinational path from out_ready; latency and ordering are unchanged.
- When undefined: no skid buffer; in_ready is combinationally dependent on out_ready per REQ-020.

Structure
REQ-027 A shared package fp_pkg SHALL hold:
- the EXP_MAX=255 constant;
- the width constants (SUM_W=49, FRAC_W=23, GRS_W=24);
- a packed struct of pass-through fields (flags, signs, rm) reused by the rounding stage.
REQ-028 A single sub-module lzc48 (combinational 48-bit leading-zero counter, 6-bit count, all-zero flag) SHALL be instantiated in S1.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- Carry: sum_mant=49'h1_0000_0000_0000, exp_in=127 -> after 2 cycles exp_norm=128, mantissa_norm=0, grs=0, underflow=0.
- Cancellation: sum_mant=49'h0_0000_0100_0000, exp_in=127 -> lz=23, exp_norm=104, mantissa_norm=0, grs=0.
- Underflow: sum_mant=49'h0_0000_0100_0000, exp_in=10 -> underflow=1, exp_norm=0, mantissa_norm=0.
- Zero: sum_mant=0, exp_in=100, nan_in=0 -> exp_norm=0, mantissa_norm=0, underflow=0; nan_in=1 -> NaN output=1 with identical fields.
- Backpressure: 4 back-to-back inputs, out_ready low 5 cycles -> in_ready drops after 2 accepted (3 with FP_NORM_SKID_EN in the 2nd entry), all 4 emerge in order and unchanged while stalled.
- Reset mid-flight: 2 inputs accepted, rst pulsed for 1 cycle -> out_valid=0, all outputs 0, no stale result after release.
